bitmask_rebuilder: RTL and testbench

- Receive end of the essential-bit index stream produced by the 16-to-4 priority encoder.
- Consumes a valid/ready stream of 4-bit positions, MSB-first (idx 0 = bit 15, idx 15 = bit 0), plus a zero-mask flag.
- Reconstructs the original 16-bit bitmask and its popcount, then emits both on an output valid/ready port.
- Sits on the bit-serial PE writeback path, where it rebuilds skipped-bit masks for checking and recombination.

---
 rtl/bitsim_pkg.sv | 16 +
 rtl/bitmask_rebuilder_pdecoder.sv | 22 ++
 rtl/bitmask_rebuilder.sv | 183 ++++++++++++++++++
 tb/tb_bitmask_rebuilder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bitsim_pkg.sv
// Shared types for the bit-serial PE index path: mask/index widths and rebuilder states.
package bitsim_pkg;

  localparam int MASK_W = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } rebuild_state_t;

  typedef logic [MASK_W-1:0] mask_t;
  typedef logic [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/bitmask_rebuilder_pdecoder.sv
// pdecoder_4to16: index-to-onehot decoder, MSB-first (idx 0 -> bit WIDTH-1), inverse of the priority encoder.
module pdecoder_4to16 #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] bit_sel_s;

  assign bit_sel_s = MAX_IDX - idx;

  // Single set bit at the mirrored position.
  always_comb begin
    onehot            = '0;
    onehot[bit_sel_s] = 1'b1;
  end

endmodule

// File: rtl/bitmask_rebuilder.sv
// bitmask_rebuilder: rebuilds a bitmask and its popcount from an MSB-first index stream.
// Optional index-ordering check and out_err reporting: define BITMASK_REBUILDER_ORDER_CHECK_EN.
module bitmask_rebuilder #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_zero,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [IDX_W:0]   out_count,
  output logic             out_err
);

  import bitsim_pkg::*;

  localparam int CNT_W = IDX_W + 1;

  rebuild_state_t   state_q, state_d;
  logic [WIDTH-1:0] acc_mask_q, acc_mask_d;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;
  logic             err_acc_q, err_acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_mask_q, out_mask_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic [WIDTH-1:0] dec_onehot_s;
  logic             beat_s;
  logic             zero_bad_s;
  logic             err_beat_s;
  logic [WIDTH-1:0] base_mask_s;
  logic [CNT_W-1:0] base_count_s;
  logic             base_err_s;
  logic [WIDTH-1:0] new_mask_s;
  logic [CNT_W-1:0] new_count_s;
  logic             new_err_s;

  pdecoder_4to16 #(.WIDTH(WIDTH)) u_dec (
    .idx    (in_idx),
    .onehot (dec_onehot_s)
  );

  assign beat_s = in_valid && in_ready_q;
  // Only a lone first-and-last beat may carry in_zero; any other zero beat is ignored.
  assign zero_bad_s = in_zero && !((state_q == IDLE) && in_last);

`ifdef BITMASK_REBUILDER_ORDER_CHECK_EN
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             order_bad_s;

  // acc_count_q != 0 means an earlier index of this mask exists to compare against.
  assign order_bad_s = !in_zero && (state_q == ACCUM) && (acc_count_q != '0) &&
                       (in_idx <= last_idx_q);
  assign err_beat_s  = order_bad_s || zero_bad_s;

  // Remember the most recent real index of the mask being built.
  always_comb begin
    last_idx_d = last_idx_q;
    if (beat_s && !in_zero && (state_q != HOLD)) begin
      last_idx_d = in_idx;
    end else begin
      last_idx_d = last_idx_q;
    end
  end

  // Last-index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_q <= '0;
    end else begin
      last_idx_q <= last_idx_d;
    end
  end
`else
  assign err_beat_s = 1'b0;
`endif

  // Merge the current beat into a fresh or ongoing accumulation.
  always_comb begin
    base_mask_s  = (state_q == IDLE) ? '0   : acc_mask_q;
    base_count_s = (state_q == IDLE) ? '0   : acc_count_q;
    base_err_s   = (state_q == IDLE) ? 1'b0 : err_acc_q;
    if (in_zero) begin
      new_mask_s  = base_mask_s;
      new_count_s = base_count_s;
    end else begin
      new_mask_s  = base_mask_s | dec_onehot_s;
      new_count_s = base_count_s + CNT_W'(((base_mask_s & dec_onehot_s) == '0) ? 1'b1 : 1'b0);
    end
    new_err_s = base_err_s | err_beat_s;
  end

  // Next-state logic for the accumulate / hold sequence.
  always_comb begin
    state_d     = state_q;
    acc_mask_d  = acc_mask_q;
    acc_count_d = acc_count_q;
    err_acc_d   = err_acc_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat_s) begin
          acc_mask_d  = new_mask_s;
          acc_count_d = new_count_s;
          err_acc_d   = new_err_s;
          if (in_last) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_mask_d  = new_mask_s;
            out_count_d = new_count_s;
            out_err_d   = new_err_s;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_mask_d  = '0;
          acc_count_d = '0;
          err_acc_d   = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        acc_mask_d  = '0;
        acc_count_d = '0;
        err_acc_d   = 1'b0;
      end
    endcase
    in_ready_d = (state_d != HOLD);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_mask_q  <= '0;
      acc_count_q <= '0;
      err_acc_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_mask_q  <= acc_mask_d;
      acc_count_q <= acc_count_d;
      err_acc_q   <= err_acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bitmask_rebuilder.sv
// Directed self-checking bench for bitmask_rebuilder.
module tb_bitmask_rebuilder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_idx;
  logic        in_zero;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mask;
  logic [4:0]  out_count;
  logic        out_err;

  int total = 0;
  int bad   = 0;

`ifdef BITMASK_REBUILDER_ORDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  bitmask_rebuilder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_zero   (in_zero),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] idx, input logic z, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_idx   = idx;
    in_zero  = z;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_idx   = 4'hx;
    in_zero  = 1'bx;
    in_last  = 1'bx;
  endtask

  task automatic check_out(input string tag, input logic [15:0] m, input logic [4:0] c, input logic e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_mask"},  32'(out_mask),  32'(m));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_err"},   32'(out_err),   32'(e));
    chk({tag, "_rdy"},   32'(in_ready),  32'd0);
  endtask

  // Pop the held mask and confirm the block is ready again.
  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_pop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pop_rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_idx    = 4'h0;
    in_zero   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rdy",   32'(in_ready),  32'd0);
    chk("rst_mask",  32'(out_mask),  32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_err",   32'(out_err),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    // Single beat idx 0 -> MSB.
    chk("t1_pre_valid", 32'(out_valid), 32'd0);
    send(4'd0, 1'b0, 1'b1);
    check_out("t1", 16'h8000, 5'd1, 1'b0);
    take("t1");

    // Three beats, then back-pressure for 5 cycles.
    send(4'd2, 1'b0, 1'b0);
    send(4'd5, 1'b0, 1'b0);
    chk("t2_mid_valid", 32'(out_valid), 32'd0);
    send(4'd15, 1'b0, 1'b1);
    check_out("t2", 16'h2401, 5'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_mask",  32'(out_mask),  32'h2401);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_rdy",   32'(in_ready),  32'd0);
    end
    take("t2");

    // Lone zero beat.
    send(4'd9, 1'b1, 1'b1);
    check_out("t3", 16'h0000, 5'd0, 1'b0);
    take("t3");

    // Duplicate index.
    send(4'd7, 1'b0, 1'b0);
    send(4'd7, 1'b0, 1'b1);
    check_out("t4", 16'h0100, 5'd1, EXP_ERR);
    take("t4");

    // Out-of-order index: both bits still set.
    send(4'd9, 1'b0, 1'b0);
    send(4'd4, 1'b0, 1'b1);
    check_out("t5", 16'h0840, 5'd2, EXP_ERR);
    take("t5");

    // Zero flag on a non-first beat must not disturb the mask.
    send(4'd3, 1'b0, 1'b0);
    send(4'd0, 1'b1, 1'b1);
    check_out("t6", 16'h1000, 5'd1, EXP_ERR);
    take("t6");

    // Error from the previous mask must not leak into the next one.
    send(4'd6, 1'b0, 1'b1);
    check_out("t7", 16'h0200, 5'd1, 1'b0);
    take("t7");

    // All sixteen indices ascending.
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b0, (i == 15) ? 1'b1 : 1'b0);
    end
    check_out("t8", 16'hFFFF, 5'd16, 1'b0);
    take("t8");

    // Reset mid-mask: partial mask discarded.
    send(4'd1, 1'b0, 1'b0);
    send(4'd3, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm_valid",     32'(out_valid),       32'd0);
    chk("rm_acc_mask",  32'(dut.acc_mask_q),  32'd0);
    chk("rm_acc_count", 32'(dut.acc_count_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rm_after_valid", 32'(out_valid), 32'd0);
    send(4'd4, 1'b0, 1'b1);
    check_out("t9", 16'h0800, 5'd1, 1'b0);

    // Reset during HOLD: out_valid drops without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rh_valid", 32'(out_valid), 32'd0);
    chk("rh_mask",  32'(out_mask),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rh_after_valid", 32'(out_valid), 32'd0);
    chk("rh_after_rdy",   32'(in_ready),  32'd1);
    send(4'd15, 1'b0, 1'b1);
    check_out("t10", 16'h0001, 5'd1, 1'b0);
    take("t10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
